mcalu_rs: RTL and testbench
===========================

MCALU_RS -- requirements
Module: mcalu_rs

Interface
REQ-001 Parameter: ENTRIES, 4, number of reservation-station slots (fixed at 4 in this revision).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 dis_valid  input  1  dispatch request.
REQ-005 dis_op  input  5  mcalu opcode (bit 4 = multi-cycle op).
REQ-006 dis_robid  input  7  ROB tag of instruction.
REQ-007 dis_rd  input  6  destination register.
REQ-008 dis_op1_rdy, dis_op2_rdy  input  1 each  operand value is valid.
REQ-009 dis_op1_tag, dis_op2_tag  input  7 each  producer ROB tag when not ready.
REQ-010 dis_op1, dis_op2  input  32 each  operand values when ready.
REQ-011 rs_stall  output  1  all slots occupied; dispatch not accepted.
REQ-012 wb_valid  input  1  result broadcast valid.
REQ-013 wb_robid  input  7  broadcast producer tag.
REQ-014 wb_result  input  32  broadcast value.
REQ-015 exers_mcalu_issue  output  1  issue valid to mcalu.
REQ-016 exers_mcalu_op  output  5; exers_robid  output  7; exers_rd  output  6; exers_op1, exers_op2  output  32 each  issued fields.
REQ-017 mcalu_stall  input  1  mcalu not accepting; issue held.
REQ-018 rob_flush  input  1  squash all entries.

Function
REQ-019 Per slot: valid, op, robid, rd, and per operand {rdy, tag, value}; plus 4x4 age matrix (older[i][j]).
REQ-020 rs_stall = all slots valid (registered state only; a slot freed this cycle is not reusable until next cycle).
REQ-021 dis_valid & ~rs_stall: write lowest-index free slot; set older[new][*]=0 and older[k][new]=1 for every valid k.
REQ-022 dis_valid while rs_stall: request ignored; upstream holds.
REQ-023 Wakeup: wb_valid, any valid slot operand with rdy=0 and tag==wb_robid -> capture wb_result, rdy=1, next edge.
REQ-024 Dispatch bypass: dispatched operand with rdy=0 and tag==wb_robid while wb_valid in the same cycle -> stored rdy=1, value=wb_result.
REQ-025 Slot eligible when valid and both operand rdy bits set in registered state (no same-cycle wakeup-to-issue).
REQ-026 Select: eligible slot older than every other eligible slot; exactly one selected.
REQ-027 exers_mcalu_issue = any eligible (combinational); fields driven from selected slot; all fields 0 when no slot eligible.
REQ-028 Selected slot freed at edge only when exers_mcalu_issue & ~mcalu_stall; under mcalu_stall outputs remain stable unless an older slot becomes eligible.
REQ-029 Minimum latency: dispatch with both operands ready at edge N -> issue asserted cycle N+1; wakeup at edge N -> eligible N+1.
REQ-030 Simultaneous dispatch, wakeup and issue in one cycle all take effect; freed slot and new slot never alias.
REQ-031 rob_flush (synchronous): clear all valid bits; flush wins over same-cycle dispatch and wakeup; exers_mcalu_issue deasserts following edge.

Reset
REQ-032 rst asserted: all valid=0, age matrix=0 immediately (asynchronous); rs_stall=0, exers_mcalu_issue=0, all issue fields 0.
REQ-033 rst asserted mid-operation discards every entry; no issue on the edge of deassertion.

Verification
REQ-034 Dispatch op=5'h00, op1=3, op2=4 both ready, mcalu_stall=0 -> next cycle issue=1, op1=3, op2=4, robid/rd echoed; slot free cycle after.
REQ-035 Dispatch robid=10 op1 waiting tag=5; then wb_valid robid=5 result=32'hDEAD -> issue cycle after broadcast with op1=32'hDEAD.
REQ-036 Fill 4 slots with unready ops -> rs_stall=1; 5th dispatch dropped; one wakeup+issue -> rs_stall=0 next cycle.
REQ-037 Dispatch A (robid 1) then B (robid 2), both become ready same cycle -> A issued first; B on following accepted cycle.
REQ-038 Hold mcalu_stall=1 for 3 cycles with ready entry -> issue=1, fields constant, entry retained; released -> freed.
REQ-039 Occupied slots, assert rob_flush with same-cycle dispatch -> all empty, issue=0 next cycle; async rst mid-flight -> outputs 0 without clock edge.

Source files
------------

// File: rtl/mcalu_rs_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mcalu_rs_if : dispatch / writeback / issue bundle of the mcalu RS        |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
interface mcalu_rs_if;
  logic        dis_valid;
  logic [4:0]  dis_op;
  logic [6:0]  dis_robid;
  logic [5:0]  dis_rd;
  logic        dis_op1_rdy;
  logic        dis_op2_rdy;
  logic [6:0]  dis_op1_tag;
  logic [6:0]  dis_op2_tag;
  logic [31:0] dis_op1;
  logic [31:0] dis_op2;
  logic        rs_stall;
  logic        wb_valid;
  logic [6:0]  wb_robid;
  logic [31:0] wb_result;
  logic        exers_mcalu_issue;
  logic [4:0]  exers_mcalu_op;
  logic [6:0]  exers_robid;
  logic [5:0]  exers_rd;
  logic [31:0] exers_op1;
  logic [31:0] exers_op2;
  logic        mcalu_stall;
  logic        rob_flush;

  modport master (
    output dis_valid, dis_op, dis_robid, dis_rd, dis_op1_rdy, dis_op2_rdy,
           dis_op1_tag, dis_op2_tag, dis_op1, dis_op2,
           wb_valid, wb_robid, wb_result, mcalu_stall, rob_flush,
    input  rs_stall, exers_mcalu_issue, exers_mcalu_op, exers_robid,
           exers_rd, exers_op1, exers_op2
  );

  modport slave (
    input  dis_valid, dis_op, dis_robid, dis_rd, dis_op1_rdy, dis_op2_rdy,
           dis_op1_tag, dis_op2_tag, dis_op1, dis_op2,
           wb_valid, wb_robid, wb_result, mcalu_stall, rob_flush,
    output rs_stall, exers_mcalu_issue, exers_mcalu_op, exers_robid,
           exers_rd, exers_op1, exers_op2
  );
endinterface
`default_nettype wire

// File: rtl/mcalu_rs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mcalu_rs : 4-entry reservation station, oldest-ready-first issue         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mcalu_rs #(
  parameter int ENTRIES = 4
) (
  input logic       clk,
  input logic       rst,
  mcalu_rs_if.slave bus
);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [4:0]         op_q    [ENTRIES];
  logic [4:0]         op_d    [ENTRIES];
  logic [6:0]         robid_q [ENTRIES];
  logic [6:0]         robid_d [ENTRIES];
  logic [5:0]         rd_q    [ENTRIES];
  logic [5:0]         rd_d    [ENTRIES];
  logic [6:0]         tag1_q  [ENTRIES];
  logic [6:0]         tag1_d  [ENTRIES];
  logic [6:0]         tag2_q  [ENTRIES];
  logic [6:0]         tag2_d  [ENTRIES];
  logic [31:0]        val1_q  [ENTRIES];
  logic [31:0]        val1_d  [ENTRIES];
  logic [31:0]        val2_q  [ENTRIES];
  logic [31:0]        val2_d  [ENTRIES];
  // older_q[i][j] set means slot i was dispatched before slot j
  logic [ENTRIES-1:0] older_q [ENTRIES];
  logic [ENTRIES-1:0] older_d [ENTRIES];

  logic [ENTRIES-1:0] w_elig, w_sel, w_free;
  logic               w_accept, w_fire, w_byp1, w_byp2;

  assign w_elig   = valid_q & rdy1_q & rdy2_q;
  assign w_free   = ~valid_q & (valid_q + {{(ENTRIES-1){1'b0}}, 1'b1});
  assign w_accept = bus.dis_valid & ~(&valid_q);
  assign w_fire   = (|w_elig) & ~bus.mcalu_stall;
  assign w_byp1   = bus.wb_valid & (bus.dis_op1_tag == bus.wb_robid);
  assign w_byp2   = bus.wb_valid & (bus.dis_op2_tag == bus.wb_robid);

  assign bus.rs_stall          = &valid_q;
  assign bus.exers_mcalu_issue = |w_elig;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_sel[i] = w_elig[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if ((j != i) && w_elig[j] && !older_q[i][j]) w_sel[i] = 1'b0;
      end
    end
  end

  always_comb begin
    bus.exers_mcalu_op = '0;
    bus.exers_robid    = '0;
    bus.exers_rd       = '0;
    bus.exers_op1      = '0;
    bus.exers_op2      = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_sel[i]) begin
        bus.exers_mcalu_op = op_q[i];
        bus.exers_robid    = robid_q[i];
        bus.exers_rd       = rd_q[i];
        bus.exers_op1      = val1_q[i];
        bus.exers_op2      = val2_q[i];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    for (int i = 0; i < ENTRIES; i++) begin
      op_d[i]    = op_q[i];
      robid_d[i] = robid_q[i];
      rd_d[i]    = rd_q[i];
      tag1_d[i]  = tag1_q[i];
      tag2_d[i]  = tag2_q[i];
      val1_d[i]  = val1_q[i];
      val2_d[i]  = val2_q[i];
      older_d[i] = older_q[i];
    end
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && bus.wb_valid && !rdy1_q[i] && (tag1_q[i] == bus.wb_robid)) begin
        rdy1_d[i] = 1'b1;
        val1_d[i] = bus.wb_result;
      end
      if (valid_q[i] && bus.wb_valid && !rdy2_q[i] && (tag2_q[i] == bus.wb_robid)) begin
        rdy2_d[i] = 1'b1;
        val2_d[i] = bus.wb_result;
      end
      if (w_fire && w_sel[i]) valid_d[i] = 1'b0;
    end
    // The free slot is invalid in registered state, so it never aliases the issuing slot
    for (int i = 0; i < ENTRIES; i++) begin
      if (w_accept && w_free[i]) begin
        valid_d[i] = 1'b1;
        op_d[i]    = bus.dis_op;
        robid_d[i] = bus.dis_robid;
        rd_d[i]    = bus.dis_rd;
        tag1_d[i]  = bus.dis_op1_tag;
        tag2_d[i]  = bus.dis_op2_tag;
        rdy1_d[i]  = bus.dis_op1_rdy | w_byp1;
        rdy2_d[i]  = bus.dis_op2_rdy | w_byp2;
        val1_d[i]  = bus.dis_op1_rdy ? bus.dis_op1 : bus.wb_result;
        val2_d[i]  = bus.dis_op2_rdy ? bus.dis_op2 : bus.wb_result;
        older_d[i] = '0;
        for (int k = 0; k < ENTRIES; k++) begin
          if (valid_q[k]) older_d[k][i] = 1'b1;
        end
      end
    end
    if (bus.rob_flush) valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]    <= '0;
        robid_q[i] <= '0;
        rd_q[i]    <= '0;
        tag1_q[i]  <= '0;
        tag2_q[i]  <= '0;
        val1_q[i]  <= '0;
        val2_q[i]  <= '0;
        older_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]    <= op_d[i];
        robid_q[i] <= robid_d[i];
        rd_q[i]    <= rd_d[i];
        tag1_q[i]  <= tag1_d[i];
        tag2_q[i]  <= tag2_d[i];
        val1_q[i]  <= val1_d[i];
        val2_q[i]  <= val2_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mcalu_rs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mcalu_rs : directed stimulus, age-ordered behavioural model checks    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_mcalu_rs;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  mcalu_rs_if bus ();

  mcalu_rs #(.ENTRIES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: an entry is a record stamped with its dispatch sequence number
  bit          m_v  [4] = '{default: 1'b0};
  logic [4:0]  m_op [4];
  logic [6:0]  m_rob[4];
  logic [5:0]  m_rd [4];
  bit          m_r1 [4];
  bit          m_r2 [4];
  logic [6:0]  m_t1 [4];
  logic [6:0]  m_t2 [4];
  logic [31:0] m_a  [4];
  logic [31:0] m_b  [4];
  int          m_seq[4];
  int          seq_ctr = 0;

  function automatic int m_pick();
    int best = -1;
    for (int i = 0; i < 4; i++)
      if (m_v[i] && m_r1[i] && m_r2[i] && (best < 0 || m_seq[i] < m_seq[best])) best = i;
    return best;
  endfunction

  function automatic bit m_full();
    return m_v[0] && m_v[1] && m_v[2] && m_v[3];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin : model
    int pk;
    int fs;
    bit full;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
    end else begin
      pk   = m_pick();
      full = m_full();
      fs   = -1;
      for (int i = 3; i >= 0; i--) if (!m_v[i]) fs = i;
      if (bus.rob_flush) begin
        for (int i = 0; i < 4; i++) m_v[i] = 1'b0;
      end else begin
        if (bus.wb_valid) begin
          for (int i = 0; i < 4; i++) begin
            if (m_v[i] && !m_r1[i] && m_t1[i] == bus.wb_robid) begin m_r1[i] = 1'b1; m_a[i] = bus.wb_result; end
            if (m_v[i] && !m_r2[i] && m_t2[i] == bus.wb_robid) begin m_r2[i] = 1'b1; m_b[i] = bus.wb_result; end
          end
        end
        if (pk >= 0 && !bus.mcalu_stall) m_v[pk] = 1'b0;
        if (bus.dis_valid && !full) begin
          m_v[fs]   = 1'b1;
          m_op[fs]  = bus.dis_op;
          m_rob[fs] = bus.dis_robid;
          m_rd[fs]  = bus.dis_rd;
          m_t1[fs]  = bus.dis_op1_tag;
          m_t2[fs]  = bus.dis_op2_tag;
          m_r1[fs]  = bus.dis_op1_rdy || (bus.wb_valid && bus.dis_op1_tag == bus.wb_robid);
          m_r2[fs]  = bus.dis_op2_rdy || (bus.wb_valid && bus.dis_op2_tag == bus.wb_robid);
          m_a[fs]   = bus.dis_op1_rdy ? bus.dis_op1 : bus.wb_result;
          m_b[fs]   = bus.dis_op2_rdy ? bus.dis_op2 : bus.wb_result;
          m_seq[fs] = seq_ctr;
          seq_ctr++;
        end
      end
    end
  end

  always @(negedge clk) begin : cmp
    int pk;
    pk = m_pick();
    chk("m_stall", 32'(bus.rs_stall), 32'(m_full()));
    chk("m_issue", 32'(bus.exers_mcalu_issue), 32'(pk >= 0));
    chk("m_op",    32'(bus.exers_mcalu_op), (pk >= 0) ? 32'(m_op[pk])  : 32'd0);
    chk("m_robid", 32'(bus.exers_robid),    (pk >= 0) ? 32'(m_rob[pk]) : 32'd0);
    chk("m_rd",    32'(bus.exers_rd),       (pk >= 0) ? 32'(m_rd[pk])  : 32'd0);
    chk("m_op1",   bus.exers_op1,           (pk >= 0) ? m_a[pk]        : 32'd0);
    chk("m_op2",   bus.exers_op2,           (pk >= 0) ? m_b[pk]        : 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dis_valid   = 1'b0; bus.dis_op      = '0; bus.dis_robid = '0; bus.dis_rd = '0;
    bus.dis_op1_rdy = 1'b0; bus.dis_op2_rdy = 1'b0;
    bus.dis_op1_tag = '0;   bus.dis_op2_tag = '0;
    bus.dis_op1     = '0;   bus.dis_op2     = '0;
    bus.wb_valid    = 1'b0; bus.wb_robid    = '0; bus.wb_result = '0;
    bus.mcalu_stall = 1'b0; bus.rob_flush   = 1'b0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [6:0] rob, input logic [5:0] rd,
                      input logic r1, input logic [6:0] t1, input logic [31:0] v1,
                      input logic r2, input logic [6:0] t2, input logic [31:0] v2);
    bus.dis_valid   = 1'b1; bus.dis_op = op; bus.dis_robid = rob; bus.dis_rd = rd;
    bus.dis_op1_rdy = r1;   bus.dis_op1_tag = t1; bus.dis_op1 = v1;
    bus.dis_op2_rdy = r2;   bus.dis_op2_tag = t2; bus.dis_op2 = v2;
  endtask

  task automatic wb(input logic [6:0] rob, input logic [31:0] res);
    bus.wb_valid = 1'b1; bus.wb_robid = rob; bus.wb_result = res;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    chk("reset_stall", 32'(bus.rs_stall), 32'd0);
    chk("reset_issue", 32'(bus.exers_mcalu_issue), 32'd0);
    rst = 1'b0;

    // Both operands ready: issues one cycle after dispatch, then frees
    disp(5'h00, 7'd7, 6'd3, 1'b1, 7'd0, 32'd3, 1'b1, 7'd0, 32'd4); tick(); idle();
    chk("t1_issue", 32'(bus.exers_mcalu_issue), 32'd1);
    chk("t1_op1",   bus.exers_op1, 32'd3);
    chk("t1_op2",   bus.exers_op2, 32'd4);
    chk("t1_robid", 32'(bus.exers_robid), 32'd7);
    chk("t1_rd",    32'(bus.exers_rd), 32'd3);
    tick();
    chk("t1_freed", 32'(bus.exers_mcalu_issue), 32'd0);

    // Wakeup from broadcast
    disp(5'h11, 7'd10, 6'd12, 1'b0, 7'd5, 32'd0, 1'b1, 7'd0, 32'd9); tick(); idle();
    chk("t2_wait", 32'(bus.exers_mcalu_issue), 32'd0);
    wb(7'd5, 32'hDEAD); tick(); idle();
    chk("t2_issue", 32'(bus.exers_mcalu_issue), 32'd1);
    chk("t2_op1",   bus.exers_op1, 32'hDEAD);
    chk("t2_robid", 32'(bus.exers_robid), 32'd10);
    tick();

    // Fill, drop a fifth dispatch, then drain one
    for (int i = 0; i < 4; i++) begin
      disp(5'h02, 7'(20 + i), 6'(i), 1'b0, 7'(30 + i), 32'd0, 1'b1, 7'd0, 32'(i)); tick();
    end
    idle();
    chk("t3_full", 32'(bus.rs_stall), 32'd1);
    disp(5'h03, 7'd24, 6'd9, 1'b1, 7'd0, 32'd1, 1'b1, 7'd0, 32'd2); tick(); idle();
    chk("t3_drop", 32'(bus.exers_mcalu_issue), 32'd0);
    wb(7'd30, 32'h55); tick(); idle();
    chk("t3_wake_robid", 32'(bus.exers_robid), 32'd20);
    chk("t3_wake_op1",   bus.exers_op1, 32'h55);
    chk("t3_still_full", 32'(bus.rs_stall), 32'd1);
    tick();
    chk("t3_unstall", 32'(bus.rs_stall), 32'd0);
    chk("t3_no_issue", 32'(bus.exers_mcalu_issue), 32'd0);

    // Flush beats a same-cycle dispatch
    disp(5'h04, 7'd40, 6'd1, 1'b1, 7'd0, 32'd1, 1'b1, 7'd0, 32'd1); bus.rob_flush = 1'b1; tick(); idle();
    chk("flush_issue", 32'(bus.exers_mcalu_issue), 32'd0);
    chk("flush_stall", 32'(bus.rs_stall), 32'd0);
    tick();
    chk("flush_after", 32'(bus.exers_mcalu_issue), 32'd0);

    // Age beats slot index: B lands in a lower slot than older A
    disp(5'h05, 7'd5, 6'd1, 1'b0, 7'd62, 32'd0, 1'b1, 7'd0, 32'd5); tick();
    disp(5'h06, 7'd1, 6'd2, 1'b0, 7'd61, 32'd0, 1'b1, 7'd0, 32'd6); tick(); idle();
    wb(7'd62, 32'h62); tick(); idle();
    chk("t4_p", 32'(bus.exers_robid), 32'd5);
    tick();
    disp(5'h07, 7'd2, 6'd3, 1'b0, 7'd61, 32'd0, 1'b1, 7'd0, 32'd7); tick(); idle();
    wb(7'd61, 32'h61); tick(); idle();
    chk("t4_first",  32'(bus.exers_robid), 32'd1);
    tick();
    chk("t4_second", 32'(bus.exers_robid), 32'd2);
    tick();
    chk("t4_empty", 32'(bus.exers_mcalu_issue), 32'd0);

    // Dispatch bypass, then hold under mcalu_stall
    disp(5'h08, 7'd70, 6'd4, 1'b1, 7'd0, 32'hA, 1'b0, 7'd80, 32'd0); wb(7'd80, 32'h1234); tick(); idle();
    chk("t5_byp_op2", bus.exers_op2, 32'h1234);
    bus.mcalu_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_issue", 32'(bus.exers_mcalu_issue), 32'd1);
      chk("t5_hold_robid", 32'(bus.exers_robid), 32'd70);
    end
    bus.mcalu_stall = 1'b0; tick();
    chk("t5_freed", 32'(bus.exers_mcalu_issue), 32'd0);

    // Issue and dispatch in the same cycle
    disp(5'h09, 7'd90, 6'd5, 1'b1, 7'd0, 32'd1, 1'b1, 7'd0, 32'd2); tick();
    disp(5'h0A, 7'd91, 6'd6, 1'b1, 7'd0, 32'd3, 1'b1, 7'd0, 32'd4); tick(); idle();
    chk("t7_next", 32'(bus.exers_robid), 32'd91);
    tick();

    // Async reset mid-cycle clears outputs with no clock edge
    disp(5'h0B, 7'd95, 6'd7, 1'b1, 7'd0, 32'd8, 1'b1, 7'd0, 32'd9); tick(); idle();
    chk("t8_pre", 32'(bus.exers_mcalu_issue), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t8_rst_issue", 32'(bus.exers_mcalu_issue), 32'd0);
    chk("t8_rst_robid", 32'(bus.exers_robid), 32'd0);
    chk("t8_rst_op1",   bus.exers_op1, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t8_post", 32'(bus.exers_mcalu_issue), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
